// File: rtl/arq_serial_tx.sv
// Stop-and-wait ARQ serial frame transmitter.
// Buffers one frame from the mapper byte stream, shifts it out LSB-first at the
// baud rate, then waits for a serial ACK/NAK and replays the buffered frame on
// NAK or timeout until the retry budget is exhausted.
module arq_serial_tx #(
  parameter int FRAME_BYTES = 4166,
  parameter int OVERSAMPLE  = 16,
  parameter int MAX_RETRIES = 3,
  parameter int ACK_TIMEOUT = 64,
  localparam int RW         = $clog2(MAX_RETRIES + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_baud_os_en,
  input  logic [7:0]    i_data,
  input  logic          i_data_valid,
  input  logic          i_data_sof,
  output logic          o_data_ready,
  output logic          o_tx_serial,
  input  logic          i_ack_serial,
  input  logic          i_arq_en,
  output logic          o_busy,
  output logic          o_retrans_active,
  output logic [RW-1:0] o_retry_count,
  output logic          o_send_ok,
  output logic          o_send_fail
);

  localparam int AW  = $clog2(FRAME_BYTES);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int RXW = $clog2(3 * OVERSAMPLE);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [AW-1:0]  LAST_BYTE = AW'(FRAME_BYTES - 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  // ACK_RX strobe counts: start-bit midpoint, ack-bit centre, stop-bit centre
  localparam logic [RXW-1:0] RX_MID    = RXW'(OVERSAMPLE / 2 - 1);
  localparam logic [RXW-1:0] RX_BIT    = RXW'(OVERSAMPLE / 2 + OVERSAMPLE - 1);
  localparam logic [RXW-1:0] RX_STOP   = RXW'(OVERSAMPLE / 2 + 2 * OVERSAMPLE - 1);
  localparam logic [TW-1:0]  TIMEOUT   = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, ACK_WAIT, ACK_RX, NAK, OK, FAIL
  } state_t;

  state_t          state;
  logic [7:0]      mem [FRAME_BYTES];
  logic [7:0]      rd_data_p1;
  logic [AW-1:0]   byte_cnt;
  logic [AW-1:0]   mem_addr;
  logic [2:0]      bit_cnt;
  logic            last_bit;
  logic [OSW-1:0]  os_cnt;
  logic [OSW-1:0]  ack_os;
  logic [TW-1:0]   timer;
  logic [RXW-1:0]  rx_cnt;
  logic            ack_bit;
  logic            arq_lat;
  logic [2:0]      ack_sync;
  logic            ack_s;
  logic            wr_en;
  logic            bit_tick;

  assign ack_s    = ack_sync[2];
  assign wr_en    = i_data_valid && o_data_ready &&
                    ((state == LOAD) || (state == IDLE && i_data_sof));
  // A restarting SOF byte always lands at address 0; otherwise the byte counter
  // addresses both the load writes and the transmit pre-fetch.
  assign mem_addr = (wr_en && i_data_sof) ? '0 : byte_cnt;
  assign bit_tick = (state == SEND) && i_baud_os_en && (os_cnt == OS_LAST);

  // Frame buffer: single-port RAM, synchronous read of the byte being shifted
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[mem_addr] <= i_data;
    // stage p1: registered read data, settled long before the next bit_tick
    rd_data_p1 <= mem[mem_addr];
  end

  // Three-flop synchroniser for the asynchronous ACK line (idles high)
  always_ff @(posedge i_clk) begin
    if (i_rst) ack_sync <= '1;
    else       ack_sync <= {ack_sync[1:0], i_ack_serial};
  end

  // Oversample strobe counter, active only while shifting a frame out
  always_ff @(posedge i_clk) begin
    if (i_rst || state != SEND) os_cnt <= '0;
    else if (i_baud_os_en)      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
  end

  // Transmit / ARQ control FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      o_tx_serial      <= 1'b1;
      o_data_ready     <= 1'b1;
      o_busy           <= 1'b0;
      o_retrans_active <= 1'b0;
      o_retry_count    <= '0;
      o_send_ok        <= 1'b0;
      o_send_fail      <= 1'b0;
      byte_cnt         <= '0;
      bit_cnt          <= '0;
      last_bit         <= 1'b0;
      ack_os           <= '0;
      timer            <= '0;
      rx_cnt           <= '0;
      ack_bit          <= 1'b0;
      arq_lat          <= 1'b0;
    end else begin
      o_send_ok   <= 1'b0;
      o_send_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (i_data_valid && i_data_sof) begin
            byte_cnt <= AW'(1);
            arq_lat  <= i_arq_en;
            o_busy   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (i_data_valid) begin
            if (i_data_sof) begin
              byte_cnt <= AW'(1);
            end else if (byte_cnt == LAST_BYTE) begin
              byte_cnt     <= '0;
              bit_cnt      <= '0;
              last_bit     <= 1'b0;
              o_data_ready <= 1'b0;
              state        <= SEND;
            end else begin
              byte_cnt <= byte_cnt + AW'(1);
            end
          end
        end
        SEND: begin
          if (bit_tick) begin
            if (last_bit) begin
              o_tx_serial <= 1'b1;
              timer       <= '0;
              ack_os      <= '0;
              if (arq_lat) begin
                state <= ACK_WAIT;
              end else begin
                o_send_ok <= 1'b1;
                state     <= OK;
              end
            end else begin
              o_tx_serial <= rd_data_p1[bit_cnt];
              bit_cnt     <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_cnt == LAST_BYTE) last_bit <= 1'b1;
                else                       byte_cnt <= byte_cnt + AW'(1);
              end
            end
          end
        end
        ACK_WAIT: begin
          if (!ack_s) begin
            rx_cnt <= '0;
            state  <= ACK_RX;
          end else if (timer == TIMEOUT) begin
            state <= NAK;
          end else if (i_baud_os_en) begin
            if (ack_os == OS_LAST) begin
              ack_os <= '0;
              timer  <= timer + TW'(1);
            end else begin
              ack_os <= ack_os + OSW'(1);
            end
          end
        end
        ACK_RX: begin
          if (i_baud_os_en) begin
            rx_cnt <= rx_cnt + RXW'(1);
            // A start bit that is gone by its midpoint was noise; keep the
            // timeout running from where it was.
            if (rx_cnt == RX_MID && ack_s) begin
              state <= ACK_WAIT;
            end else if (rx_cnt == RX_BIT) begin
              ack_bit <= ack_s;
            end else if (rx_cnt == RX_STOP) begin
              if (ack_s || !ack_bit) begin
                state <= NAK;
              end else begin
                o_send_ok <= 1'b1;
                state     <= OK;
              end
            end
          end
        end
        NAK: begin
          if (o_retry_count == RETRY_MAX) begin
            o_send_fail <= 1'b1;
            state       <= FAIL;
          end else begin
            o_retry_count    <= o_retry_count + RW'(1);
            o_retrans_active <= 1'b1;
            byte_cnt         <= '0;
            bit_cnt          <= '0;
            last_bit         <= 1'b0;
            state            <= SEND;
          end
        end
        OK, FAIL: begin
          o_retry_count    <= '0;
          o_retrans_active <= 1'b0;
          o_data_ready     <= 1'b1;
          o_busy           <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arq_serial_tx.sv
// Directed testbench for arq_serial_tx with an 8-byte frame and 4x oversampling.
module tb_arq_serial_tx;

  localparam int FB = 8;
  localparam int OS = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_baud_os_en = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_data_valid = 1'b0;
  logic       i_data_sof = 1'b0;
  logic       o_data_ready;
  logic       o_tx_serial;
  logic       i_ack_serial = 1'b1;
  logic       i_arq_en = 1'b0;
  logic       o_busy;
  logic       o_retrans_active;
  logic [1:0] o_retry_count;
  logic       o_send_ok;
  logic       o_send_fail;

  arq_serial_tx #(
    .FRAME_BYTES(FB), .OVERSAMPLE(OS), .MAX_RETRIES(3), .ACK_TIMEOUT(64)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_baud_os_en(i_baud_os_en),
    .i_data(i_data), .i_data_valid(i_data_valid), .i_data_sof(i_data_sof),
    .o_data_ready(o_data_ready), .o_tx_serial(o_tx_serial),
    .i_ack_serial(i_ack_serial), .i_arq_en(i_arq_en), .o_busy(o_busy),
    .o_retrans_active(o_retrans_active), .o_retry_count(o_retry_count),
    .o_send_ok(o_send_ok), .o_send_fail(o_send_fail)
  );

  always #5 i_clk = ~i_clk;

  // Baud strobe: high one cycle out of every two
  initial forever begin
    @(negedge i_clk);
    i_baud_os_en = ~i_baud_os_en;
  end

  // Frame words: byte k of the frame is w[8k+:8], so bit k on the wire is w[k]
  localparam logic [63:0] WA = 64'hAA557E81_F00F3CA5;
  localparam logic [63:0] WB = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WC = 64'hDEAD_BEEF_C0FF_EE42;
  localparam logic [63:0] WD = 64'h8000_0000_0000_0001;
  localparam logic [63:0] WE = 64'h7766_5544_3322_113C;

  int checks = 0;
  int fails  = 0;

  int cyc = 0;
  int ok_cnt = 0;
  int fail_cnt = 0;
  int retr_cnt = 0;

  // Pulse/level counters sampled on the falling edge
  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_send_ok)        ok_cnt   <= ok_cnt + 1;
    if (o_send_fail)      fail_cnt <= fail_cnt + 1;
    if (o_retrans_active) retr_cnt <= retr_cnt + 1;
  end

  logic [63:0] frames    [32];
  logic        frame_hi  [32];
  int          start_cyc [32];
  int          end_cyc   [32];
  int          frame_cnt = 0;

  // Serial capture: a frame starts when ready falls (first send) or when the
  // retry count steps up (replay). Bit k is driven on strobe 4(k+1) after the
  // start and sampled two strobes later; strobe 260 returns the line high.
  initial begin : monitor
    logic        prev_ready;
    logic [1:0]  prev_rc;
    logic [63:0] bits;
    logic        hi;
    logic        aborted;
    int          n;
    int          st;
    int          en;
    prev_ready = 1'b1;
    prev_rc    = 2'd0;
    forever begin
      @(posedge i_clk); #1;
      if (!i_rst && ((prev_ready && !o_data_ready) ||
                     (o_retry_count != prev_rc && o_retry_count != 2'd0))) begin
        st = cyc; en = 0; n = 0; bits = '0; hi = 1'b0; aborted = 1'b0;
        while (n < 262 && !aborted) begin
          @(posedge i_clk); #1;
          if (i_rst) aborted = 1'b1;
          else if (i_baud_os_en) begin
            n++;
            if (n >= 6 && n <= 258 && (n % 4) == 2) bits[(n - 6) / 4] = o_tx_serial;
            if (n == 260) en = cyc;
            if (n == 262) hi = o_tx_serial;
          end
        end
        if (!aborted) begin
          frames[frame_cnt % 32]    = bits;
          frame_hi[frame_cnt % 32]  = hi;
          start_cyc[frame_cnt % 32] = st;
          end_cyc[frame_cnt % 32]   = en;
          frame_cnt++;
        end
      end
      prev_ready = o_data_ready;
      prev_rc    = o_retry_count;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input logic [63:0] w, input logic arq);
    @(negedge i_clk);
    i_arq_en = arq; i_data_valid = 1'b1; i_data_sof = 1'b1; i_data = w[7:0];
    for (int i = 1; i < FB; i++) begin
      @(negedge i_clk);
      i_data_sof = 1'b0; i_data = w[8*i +: 8];
    end
    @(negedge i_clk);
    i_data_valid = 1'b0;
  endtask

  task automatic send_ack(input logic ack_b, input logic stop_b);
    @(negedge i_clk); i_ack_serial = 1'b0;
    repeat (2 * OS) @(negedge i_clk);
    i_ack_serial = ack_b;
    repeat (2 * OS) @(negedge i_clk);
    i_ack_serial = stop_b;
    repeat (2 * OS) @(negedge i_clk);
    i_ack_serial = 1'b1;
  endtask

  task automatic wait_frame(input int target);
    int t;
    t = 0;
    while (frame_cnt < target && t < 5000) begin @(negedge i_clk); t++; end
    checks++;
    if (frame_cnt < target) begin
      fails++;
      $display("FAIL wait_frame: frames seen %0d, required %0d", frame_cnt, target);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 3000) begin @(negedge i_clk); t++; end
    checks++;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL wait_idle: busy=%b required 0", o_busy); end
  endtask

  task automatic pulse_reset();
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checks += 6;
    if (o_tx_serial !== 1'b1)      begin fails++; $display("FAIL reset tx: got %b want 1", o_tx_serial); end
    if (o_data_ready !== 1'b1)     begin fails++; $display("FAIL reset ready: got %b want 1", o_data_ready); end
    if (o_busy !== 1'b0)           begin fails++; $display("FAIL reset busy: got %b want 0", o_busy); end
    if (o_retrans_active !== 1'b0) begin fails++; $display("FAIL reset retrans: got %b want 0", o_retrans_active); end
    if (o_retry_count !== 2'd0)    begin fails++; $display("FAIL reset retry: got %0d want 0", o_retry_count); end
    if (o_send_ok !== 1'b0 || o_send_fail !== 1'b0) begin
      fails++; $display("FAIL reset pulses: ok=%b fail=%b want 0 0", o_send_ok, o_send_fail);
    end
  endtask

  task automatic test_arq_off();
    int base; int ok0;
    base = frame_cnt; ok0 = ok_cnt;
    // stray byte without sof is swallowed in IDLE
    @(negedge i_clk); i_data_valid = 1'b1; i_data = 8'hFF;
    @(negedge i_clk); i_data_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL idle discard: busy=%b want 0", o_busy); end
    load_frame(WA, 1'b0);
    i_arq_en = 1'b1;  // must be ignored for the frame in flight
    wait_frame(base + 1);
    wait_idle();
    checks += 5;
    if (frames[base % 32] !== WA)      begin fails++; $display("FAIL arq_off frame: got %h want %h", frames[base % 32], WA); end
    if (frames[base % 32][7:0] !== 8'hA5) begin fails++; $display("FAIL arq_off first byte: got %h want a5", frames[base % 32][7:0]); end
    if (frame_hi[base % 32] !== 1'b1)  begin fails++; $display("FAIL arq_off line after frame: got %b want 1", frame_hi[base % 32]); end
    if (ok_cnt - ok0 != 1)             begin fails++; $display("FAIL arq_off ok pulses: got %0d want 1", ok_cnt - ok0); end
    if (o_retry_count !== 2'd0)        begin fails++; $display("FAIL arq_off retry: got %0d want 0", o_retry_count); end
  endtask

  task automatic test_arq_ack();
    int base; int ok0; int fl0; int rt0;
    base = frame_cnt; ok0 = ok_cnt; fl0 = fail_cnt; rt0 = retr_cnt;
    load_frame(WB, 1'b1);
    wait_frame(base + 1);
    send_ack(1'b1, 1'b0);
    wait_idle();
    checks += 4;
    if (frames[base % 32] !== WB) begin fails++; $display("FAIL ack frame: got %h want %h", frames[base % 32], WB); end
    if (ok_cnt - ok0 != 1)        begin fails++; $display("FAIL ack ok pulses: got %0d want 1", ok_cnt - ok0); end
    if (fail_cnt - fl0 != 0)      begin fails++; $display("FAIL ack fail pulses: got %0d want 0", fail_cnt - fl0); end
    if (retr_cnt - rt0 != 0)      begin fails++; $display("FAIL ack retrans cycles: got %0d want 0", retr_cnt - rt0); end
  endtask

  task automatic test_nak_retry();
    int base; int ok0;
    base = frame_cnt; ok0 = ok_cnt;
    load_frame(WC, 1'b1);
    wait_frame(base + 1);
    send_ack(1'b0, 1'b0);
    wait_frame(base + 2);
    checks += 2;
    if (o_retry_count !== 2'd1)     begin fails++; $display("FAIL nak retry after 1st: got %0d want 1", o_retry_count); end
    if (o_retrans_active !== 1'b1)  begin fails++; $display("FAIL nak retrans: got %b want 1", o_retrans_active); end
    send_ack(1'b0, 1'b0);
    wait_frame(base + 3);
    checks++;
    if (o_retry_count !== 2'd2)     begin fails++; $display("FAIL nak retry after 2nd: got %0d want 2", o_retry_count); end
    send_ack(1'b1, 1'b0);
    wait_idle();
    checks += 3;
    if (ok_cnt - ok0 != 1)          begin fails++; $display("FAIL nak ok pulses: got %0d want 1", ok_cnt - ok0); end
    if (o_retry_count !== 2'd0)     begin fails++; $display("FAIL nak retry cleared: got %0d want 0", o_retry_count); end
    if (o_retrans_active !== 1'b0)  begin fails++; $display("FAIL nak retrans cleared: got %b want 0", o_retrans_active); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (frames[(base + i) % 32] !== WC) begin
        fails++; $display("FAIL nak frame %0d: got %h want %h", i, frames[(base + i) % 32], WC);
      end
    end
  endtask

  task automatic test_timeout();
    int base; int ok0; int fl0; int gap;
    base = frame_cnt; ok0 = ok_cnt; fl0 = fail_cnt;
    load_frame(WD, 1'b1);
    wait_frame(base + 4);
    checks++;
    if (o_retry_count !== 2'd3) begin fails++; $display("FAIL timeout retry at last send: got %0d want 3", o_retry_count); end
    wait_idle();
    checks += 2;
    if (fail_cnt - fl0 != 1) begin fails++; $display("FAIL timeout fail pulses: got %0d want 1", fail_cnt - fl0); end
    if (ok_cnt - ok0 != 0)   begin fails++; $display("FAIL timeout ok pulses: got %0d want 0", ok_cnt - ok0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frames[(base + i) % 32] !== WD) begin
        fails++; $display("FAIL timeout frame %0d: got %h want %h", i, frames[(base + i) % 32], WD);
      end
    end
    // 64 bit periods of 8 clocks, plus the NAK decision and re-entry cycles
    for (int i = 0; i < 3; i++) begin
      gap = start_cyc[(base + i + 1) % 32] - end_cyc[(base + i) % 32];
      checks++;
      if (gap < 512 || gap > 516) begin
        fails++; $display("FAIL timeout gap %0d: got %0d cycles want 512..516", i, gap);
      end
    end
  endtask

  task automatic test_sof_restart();
    int base; int ok0; int fl0;
    base = frame_cnt; ok0 = ok_cnt; fl0 = fail_cnt;
    @(negedge i_clk);
    i_arq_en = 1'b1; i_data_valid = 1'b1; i_data_sof = 1'b1; i_data = 8'h11;
    for (int i = 1; i < 5; i++) begin
      @(negedge i_clk); i_data_sof = 1'b0; i_data = 8'h11 + 8'(i);
    end
    @(negedge i_clk); i_data_sof = 1'b1; i_data = WE[7:0];
    for (int i = 1; i < FB; i++) begin
      @(negedge i_clk); i_data_sof = 1'b0; i_data = WE[8*i +: 8];
    end
    @(negedge i_clk); i_data_valid = 1'b0;
    wait_frame(base + 1);
    checks += 2;
    if (frames[base % 32] !== WE)         begin fails++; $display("FAIL sof frame: got %h want %h", frames[base % 32], WE); end
    if (frames[base % 32][7:0] !== 8'h3C) begin fails++; $display("FAIL sof byte0: got %h want 3c", frames[base % 32][7:0]); end
    // two-cycle low glitch on the ACK line
    @(negedge i_clk); i_ack_serial = 1'b0;
    repeat (2) @(negedge i_clk);
    i_ack_serial = 1'b1;
    repeat (40) @(negedge i_clk);
    checks += 3;
    if (o_busy !== 1'b1)        begin fails++; $display("FAIL glitch busy: got %b want 1", o_busy); end
    if (o_retry_count !== 2'd0) begin fails++; $display("FAIL glitch retry: got %0d want 0", o_retry_count); end
    if (ok_cnt - ok0 != 0)      begin fails++; $display("FAIL glitch ok pulses: got %0d want 0", ok_cnt - ok0); end
    send_ack(1'b1, 1'b0);
    wait_idle();
    checks += 2;
    if (ok_cnt - ok0 != 1)   begin fails++; $display("FAIL glitch then ack ok: got %0d want 1", ok_cnt - ok0); end
    if (fail_cnt - fl0 != 0) begin fails++; $display("FAIL glitch then ack fail: got %0d want 0", fail_cnt - fl0); end
  endtask

  task automatic test_reset_mid();
    int base; int ok0; int fl0; int t;
    base = frame_cnt; ok0 = ok_cnt; fl0 = fail_cnt;
    // reset while shifting
    load_frame(WA, 1'b1);
    t = 0;
    while (o_data_ready && t < 100) begin @(negedge i_clk); t++; end
    repeat (100) @(negedge i_clk);
    pulse_reset();
    checks += 3;
    if (o_tx_serial !== 1'b1)  begin fails++; $display("FAIL rst send tx: got %b want 1", o_tx_serial); end
    if (o_busy !== 1'b0)       begin fails++; $display("FAIL rst send busy: got %b want 0", o_busy); end
    if (o_data_ready !== 1'b1) begin fails++; $display("FAIL rst send ready: got %b want 1", o_data_ready); end
    repeat (600) @(negedge i_clk);
    checks++;
    if (frame_cnt != base) begin fails++; $display("FAIL rst send frames: got %0d want %0d", frame_cnt, base); end
    // reset while receiving an ACK start bit
    load_frame(WB, 1'b1);
    wait_frame(base + 1);
    @(negedge i_clk); i_ack_serial = 1'b0;
    repeat (8) @(negedge i_clk);
    pulse_reset();
    checks += 2;
    if (o_tx_serial !== 1'b1) begin fails++; $display("FAIL rst ackrx tx: got %b want 1", o_tx_serial); end
    if (o_busy !== 1'b0)      begin fails++; $display("FAIL rst ackrx busy: got %b want 0", o_busy); end
    i_ack_serial = 1'b1;
    repeat (50) @(negedge i_clk);
    checks += 2;
    if (ok_cnt - ok0 != 0)   begin fails++; $display("FAIL rst ok pulses: got %0d want 0", ok_cnt - ok0); end
    if (fail_cnt - fl0 != 0) begin fails++; $display("FAIL rst fail pulses: got %0d want 0", fail_cnt - fl0); end
    // clean frame afterwards
    load_frame(WC, 1'b1);
    wait_frame(base + 2);
    send_ack(1'b1, 1'b0);
    wait_idle();
    checks += 2;
    if (frames[(base + 1) % 32] !== WC) begin fails++; $display("FAIL rst next frame: got %h want %h", frames[(base + 1) % 32], WC); end
    if (ok_cnt - ok0 != 1)              begin fails++; $display("FAIL rst next ok: got %0d want 1", ok_cnt - ok0); end
  endtask

  initial begin
    test_reset();
    test_arq_off();
    test_arq_ack();
    test_nak_retry();
    test_timeout();
    test_sof_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
